// File: rtl/acc_sequencer_if.sv
// Instruction handshake and ALU bus between the control unit, the accumulator sequencer and the ALU.
// The sequencer uses the slave modport; the master modport is the control-unit/ALU side.
interface acc_sequencer_if #(
    parameter int unsigned WORD = 16
) ();
    logic            op_valid;
    logic            op_ready;
    logic [3:0]      op_code;
    logic [WORD-1:0] op_dr;

    logic [WORD-1:0] alu_ac;
    logic [WORD-1:0] alu_dr;
    logic            alu_e;
    logic [2:0]      alu_select;
    logic [WORD-1:0] alu_out;
    logic            alu_co;
    logic            alu_ovf;
    logic            alu_n;
    logic            alu_z;

    modport master (
        output op_valid, op_code, op_dr,
        input  op_ready,
        input  alu_ac, alu_dr, alu_e, alu_select,
        output alu_out, alu_co, alu_ovf, alu_n, alu_z
    );

    modport slave (
        input  op_valid, op_code, op_dr,
        output op_ready,
        output alu_ac, alu_dr, alu_e, alu_select,
        input  alu_out, alu_co, alu_ovf, alu_n, alu_z
    );
endinterface

// File: rtl/acc_sequencer.sv
// Accumulator-side sequencer: owns AC, E and N/Z/OVF, drives the ALU for one AC-class op per 2 cycles.
// Optional macro ACC_SEQ_STICKY_OVF_EN makes flag_ovf sticky (ADD/INC set it, ovf_clr clears it).
module acc_sequencer #(
    parameter int unsigned WORD = 16
) (
    input  logic            clk,
    input  logic            rst,
    acc_sequencer_if.slave  bus,
    output logic [WORD-1:0] ac,
    output logic            e,
    output logic            flag_n,
    output logic            flag_z,
    output logic            flag_ovf,
    output logic            done,
    output logic            skip,
    input  logic            ovf_clr
);

    localparam logic [3:0] OpAnd = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpLda = 4'h3;
    localparam logic [3:0] OpCla = 4'h4;
    localparam logic [3:0] OpCle = 4'h5;
    localparam logic [3:0] OpCme = 4'h6;
    localparam logic [3:0] OpCma = 4'h7;
    localparam logic [3:0] OpCir = 4'h8;
    localparam logic [3:0] OpCil = 4'h9;
    localparam logic [3:0] OpInc = 4'hA;
    localparam logic [3:0] OpSza = 4'hB;
    localparam logic [3:0] OpSze = 4'hC;
    localparam logic [3:0] OpSpa = 4'hD;
    localparam logic [3:0] OpSna = 4'hE;

    localparam logic [2:0] SelAdd  = 3'd0;
    localparam logic [2:0] SelAnd  = 3'd1;
    localparam logic [2:0] SelTra  = 3'd2;
    localparam logic [2:0] SelCmp  = 3'd3;
    localparam logic [2:0] SelShr  = 3'd4;
    localparam logic [2:0] SelShl  = 3'd5;
    localparam logic [2:0] SelPass = 3'd7;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e          state_q, state_d;
    logic [WORD-1:0] ac_q, ac_d;
    logic [WORD-1:0] dr_q, dr_d;
    logic [3:0]      op_q, op_d;
    logic            e_q, e_d;
    logic            n_q, n_d;
    logic            z_q, z_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic            skip_q, skip_d;
    logic            accept;
    logic            ovf_arith;
    logic            ovf_logic;

    // ovf_arith: value written by ADD/INC; ovf_logic: value written by the other flag-setting ops.
`ifdef ACC_SEQ_STICKY_OVF_EN
    assign ovf_arith = ovf_q | bus.alu_ovf;
    assign ovf_logic = ovf_q;
`else
    logic unused_ovf_clr;
    assign ovf_arith      = bus.alu_ovf;
    assign ovf_logic      = 1'b0;
    assign unused_ovf_clr = ovf_clr;
`endif

    assign accept = (state_q == StIdle) && bus.op_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.op_valid) state_d = StExec;
            StExec:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.op_ready   = (state_q == StIdle);
        bus.alu_ac     = ac_q;
        bus.alu_e      = e_q;
        bus.alu_dr     = dr_q;
        bus.alu_select = SelPass;
        if (state_q == StExec) begin
            case (op_q)
                OpAnd:   bus.alu_select = SelAnd;
                OpAdd:   bus.alu_select = SelAdd;
                OpLda:   bus.alu_select = SelTra;
                OpCma:   bus.alu_select = SelCmp;
                OpCir:   bus.alu_select = SelShr;
                OpCil:   bus.alu_select = SelShl;
                OpInc: begin
                    bus.alu_select = SelAdd;
                    bus.alu_dr     = {{(WORD-1){1'b0}}, 1'b1};
                end
                default: bus.alu_select = SelPass;
            endcase
        end
    end

    // Writeback happens only on the edge that leaves EXEC; skip tests see pre-writeback AC/E.
    always_comb begin
        ac_d   = ac_q;
        e_d    = e_q;
        n_d    = n_q;
        z_d    = z_q;
        ovf_d  = ovf_q;
        op_d   = op_q;
        dr_d   = dr_q;
        done_d = 1'b0;
        skip_d = 1'b0;
        if (accept) begin
            op_d = bus.op_code;
            dr_d = bus.op_dr;
        end
        if (state_q == StExec) begin
            done_d = 1'b1;
            case (op_q)
                OpAnd, OpLda, OpCma: begin
                    ac_d  = bus.alu_out;
                    n_d   = bus.alu_n;
                    z_d   = bus.alu_z;
                    ovf_d = ovf_logic;
                end
                OpAdd, OpInc: begin
                    ac_d  = bus.alu_out;
                    e_d   = bus.alu_co;
                    n_d   = bus.alu_n;
                    z_d   = bus.alu_z;
                    ovf_d = ovf_arith;
                end
                OpCir, OpCil: begin
                    ac_d  = bus.alu_out;
                    e_d   = bus.alu_co;
                    n_d   = bus.alu_n;
                    z_d   = bus.alu_z;
                    ovf_d = ovf_logic;
                end
                OpCla: begin
                    ac_d  = '0;
                    n_d   = 1'b0;
                    z_d   = 1'b1;
                    ovf_d = ovf_logic;
                end
                OpCle:   e_d    = 1'b0;
                OpCme:   e_d    = ~e_q;
                OpSza:   skip_d = (ac_q == '0);
                OpSze:   skip_d = ~e_q;
                OpSpa:   skip_d = ~ac_q[WORD-1];
                OpSna:   skip_d = ac_q[WORD-1];
                default: ;
            endcase
        end
`ifdef ACC_SEQ_STICKY_OVF_EN
        if (ovf_clr) ovf_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q   <= '0;
            dr_q   <= '0;
            op_q   <= '0;
            e_q    <= 1'b0;
            n_q    <= 1'b0;
            z_q    <= 1'b1;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            ac_q   <= ac_d;
            dr_q   <= dr_d;
            op_q   <= op_d;
            e_q    <= e_d;
            n_q    <= n_d;
            z_q    <= z_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
            skip_q <= skip_d;
        end
    end

    assign ac       = ac_q;
    assign e        = e_q;
    assign flag_n   = n_q;
    assign flag_z   = z_q;
    assign flag_ovf = ovf_q;
    assign done     = done_q;
    assign skip     = skip_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: directed test-plan cases plus randomized traffic,
// all checked every cycle against an instruction-level model of the accumulator state.
module tb_acc_sequencer;

    localparam int unsigned W = 16;
`ifdef ACC_SEQ_STICKY_OVF_EN
    localparam bit Sticky = 1'b1;
`else
    localparam bit Sticky = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ovf_clr;
    logic [W-1:0]  ac;
    logic          e, flag_n, flag_z, flag_ovf, done, skip;

    acc_sequencer_if #(.WORD(W)) bus ();

    acc_sequencer #(.WORD(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ac       (ac),
        .e        (e),
        .flag_n   (flag_n),
        .flag_z   (flag_z),
        .flag_ovf (flag_ovf),
        .done     (done),
        .skip     (skip),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // ALU stand-in: ADD/AND/TRA/CMP(~AC)/SHR/SHL through E, anything else passes AC.
    logic [W:0] alu_sum;
    always_comb begin
        alu_sum     = {1'b0, bus.alu_ac} + {1'b0, bus.alu_dr};
        bus.alu_out = bus.alu_ac;
        bus.alu_co  = 1'b0;
        bus.alu_ovf = 1'b0;
        case (bus.alu_select)
            3'd0: begin
                bus.alu_out = alu_sum[W-1:0];
                bus.alu_co  = alu_sum[W];
                bus.alu_ovf = (bus.alu_ac[W-1] == bus.alu_dr[W-1]) &&
                              (alu_sum[W-1] != bus.alu_ac[W-1]);
            end
            3'd1: bus.alu_out = bus.alu_ac & bus.alu_dr;
            3'd2: bus.alu_out = bus.alu_dr;
            3'd3: bus.alu_out = ~bus.alu_ac;
            3'd4: begin
                bus.alu_out = {bus.alu_e, bus.alu_ac[W-1:1]};
                bus.alu_co  = bus.alu_ac[0];
            end
            3'd5: begin
                bus.alu_out = {bus.alu_ac[W-2:0], bus.alu_e};
                bus.alu_co  = bus.alu_ac[W-1];
            end
            default: ;
        endcase
        bus.alu_n = bus.alu_out[W-1];
        bus.alu_z = (bus.alu_out == '0);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: architectural state plus the one instruction in flight.
    logic [W-1:0] m_ac, lat_dr;
    logic [3:0]   lat_op;
    logic         m_e, m_n, m_z, m_ovf, m_done, m_skip, pend, m_accepted;
    bit           model_ok = 0;

    function automatic logic [2:0] sel_of(input logic [3:0] op);
        case (op)
            4'h1:    return 3'd1;
            4'h2:    return 3'd0;
            4'h3:    return 3'd2;
            4'h7:    return 3'd3;
            4'h8:    return 3'd4;
            4'h9:    return 3'd5;
            4'hA:    return 3'd0;
            default: return 3'd7;
        endcase
    endfunction

    task automatic set_nz();
        m_n = m_ac[W-1];
        m_z = (m_ac == '0);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] dr);
        logic [W-1:0] a, b;
        logic [W:0]   sum;
        logic         v;
        a = m_ac;
        case (op)
            4'h1: begin m_ac = a & dr; set_nz(); m_ovf = Sticky ? m_ovf : 1'b0; end
            4'h2, 4'hA: begin
                b     = (op == 4'h2) ? dr : 16'h0001;
                sum   = {1'b0, a} + {1'b0, b};
                m_ac  = sum[W-1:0];
                m_e   = sum[W];
                set_nz();
                v     = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
                m_ovf = Sticky ? (m_ovf | v) : v;
            end
            4'h3: begin m_ac = dr; set_nz(); m_ovf = Sticky ? m_ovf : 1'b0; end
            4'h4: begin m_ac = '0; m_n = 0; m_z = 1; m_ovf = Sticky ? m_ovf : 1'b0; end
            4'h5: m_e = 1'b0;
            4'h6: m_e = ~m_e;
            4'h7: begin m_ac = ~a; set_nz(); m_ovf = Sticky ? m_ovf : 1'b0; end
            4'h8: begin
                m_ac = {m_e, a[W-1:1]}; m_e = a[0]; set_nz();
                m_ovf = Sticky ? m_ovf : 1'b0;
            end
            4'h9: begin
                m_ac = {a[W-2:0], m_e}; m_e = a[W-1]; set_nz();
                m_ovf = Sticky ? m_ovf : 1'b0;
            end
            4'hB: m_skip = (a == '0);
            4'hC: m_skip = ~m_e;
            4'hD: m_skip = ~a[W-1];
            4'hE: m_skip = a[W-1];
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        m_accepted = 1'b0;
        m_done     = 1'b0;
        m_skip     = 1'b0;
        if (rst) begin
            m_ac = '0; m_e = 0; m_n = 0; m_z = 1; m_ovf = 0;
            pend = 0; lat_op = '0; lat_dr = '0;
            model_ok = 1;
        end else begin
            if (pend) begin
                do_op(lat_op, lat_dr);
                m_done = 1'b1;
                pend   = 1'b0;
            end else if (bus.op_valid) begin
                pend       = 1'b1;
                lat_op     = bus.op_code;
                lat_dr     = bus.op_dr;
                m_accepted = 1'b1;
            end
            if (Sticky && ovf_clr) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("op_ready", bus.op_ready, !pend);
            chk("ac", ac, m_ac);
            chk("e", e, m_e);
            chk("flag_n", flag_n, m_n);
            chk("flag_z", flag_z, m_z);
            chk("flag_ovf", flag_ovf, m_ovf);
            chk("done", done, m_done);
            chk("skip", skip, m_skip);
            chk("alu_ac", bus.alu_ac, m_ac);
            chk("alu_e", bus.alu_e, m_e);
            chk("alu_dr", bus.alu_dr, (pend && lat_op == 4'hA) ? 16'h0001 : lat_dr);
            chk("alu_select", bus.alu_select, pend ? sel_of(lat_op) : 3'd7);
        end
    end

    // Issue one op and return the EXEC-cycle select plus done/skip in the cycle after EXEC.
    task automatic run(input logic [3:0] op, input logic [W-1:0] dr,
                       output logic [2:0] sel, output logic d, output logic s);
        int n;
        n = 0;
        @(posedge clk); #2;
        while (!bus.op_ready && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 10) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: got op_ready=0 for 10 cycles, required 1");
        end
        bus.op_valid = 1'b1; bus.op_code = op; bus.op_dr = dr;
        @(posedge clk); #2;
        bus.op_valid = 1'b0;
        @(negedge clk);
        sel = bus.alu_select;
        @(posedge clk);
        @(negedge clk);
        d = done;
        s = skip;
    endtask

    logic [2:0] sel;
    logic       d, s;
    logic [7:0] done_pat, rdy_pat;
    logic [3:0] b2b_op [4];
    logic [W-1:0] b2b_dr [4];

    initial begin
        rst = 1'b1; ovf_clr = 1'b0;
        bus.op_valid = 1'b0; bus.op_code = '0; bus.op_dr = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ac", ac, 16'h0000);
        chk("rst_z", flag_z, 1);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.op_ready, 1);
        chk("rst_sel", bus.alu_select, 3'd7);

        run(4'h3, 16'h1234, sel, d, s);
        chk("lda_done_latency", d, 1);
        chk("lda_exec_sel", sel, 3'd2);
        chk("lda_ac", ac, 16'h1234);
        chk("lda_z", flag_z, 0);
        chk("lda_n", flag_n, 0);

        run(4'h3, 16'h7FFF, sel, d, s);
        run(4'h2, 16'h0001, sel, d, s);
        chk("add_ovf_ac", ac, 16'h8000);
        chk("add_ovf_e", e, 0);
        chk("add_ovf_ovf", flag_ovf, 1);
        chk("add_ovf_n", flag_n, 1);
        run(4'h2, 16'h8000, sel, d, s);
        chk("add_wrap_ac", ac, 16'h0000);
        chk("add_wrap_e", e, 1);
        chk("add_wrap_z", flag_z, 1);
        chk("add_wrap_ovf", flag_ovf, 1);
        run(4'h1, 16'hFFFF, sel, d, s);
        chk("and_after_ovf", flag_ovf, Sticky ? 1 : 0);
        @(posedge clk); #2 ovf_clr = 1'b1;
        @(posedge clk); #2 ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", flag_ovf, 0);

        run(4'h3, 16'h0001, sel, d, s);
        run(4'h8, 16'h0000, sel, d, s);
        chk("cir_ac", ac, 16'h8000);
        chk("cir_e", e, 1);
        run(4'h9, 16'h0000, sel, d, s);
        chk("cil_ac", ac, 16'h0001);
        chk("cil_e", e, 1);
        run(4'h3, 16'hFFFF, sel, d, s);
        run(4'hA, 16'h0000, sel, d, s);
        chk("inc_ac", ac, 16'h0000);
        chk("inc_e", e, 1);
        chk("inc_z", flag_z, 1);

        run(4'hB, 16'h0000, sel, d, s);
        chk("sza_skip", s, 1);
        chk("sza_done", d, 1);
        run(4'h3, 16'h8000, sel, d, s);
        run(4'hD, 16'h0000, sel, d, s);
        chk("spa_skip", s, 0);
        run(4'hE, 16'h0000, sel, d, s);
        chk("sna_skip", s, 1);
        run(4'h5, 16'h0000, sel, d, s);
        run(4'hC, 16'h0000, sel, d, s);
        chk("sze_skip", s, 1);

        // Back-to-back with op_valid held: accepts at edges 1,3,5,7, done after 2,4,6,8.
        b2b_op[0] = 4'h3; b2b_dr[0] = 16'h0003;
        b2b_op[1] = 4'h2; b2b_dr[1] = 16'h0005;
        b2b_op[2] = 4'hA; b2b_dr[2] = 16'h0000;
        b2b_op[3] = 4'h7; b2b_dr[3] = 16'h0000;
        begin
            int j;
            j = 0;
            @(posedge clk); #2;
            bus.op_valid = 1'b1; bus.op_code = b2b_op[0]; bus.op_dr = b2b_dr[0];
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #2;
                if (m_accepted) begin
                    j++;
                    if (j < 4) begin
                        bus.op_code = b2b_op[j]; bus.op_dr = b2b_dr[j];
                    end else begin
                        bus.op_valid = 1'b0;
                    end
                end
                @(negedge clk);
                done_pat[k] = done;
                rdy_pat[k]  = bus.op_ready;
            end
        end
        chk("b2b_done_pattern", done_pat, 8'hAA);
        chk("b2b_ready_pattern", rdy_pat, 8'hAA);
        chk("b2b_ac", ac, 16'hFFF6);

        // Reset while an LDA is in EXEC.
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        bus.op_valid = 1'b1; bus.op_code = 4'h3; bus.op_dr = 16'h5555;
        @(posedge clk); #2;
        bus.op_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_exec_ac", ac, 16'h0000);
        chk("rst_exec_done", done, 0);
        @(negedge clk);
        chk("rst_exec_done_late", done, 0);

        // Randomized traffic with occasional resets and ovf_clr pulses.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            rst     = ($urandom_range(0, 199) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            if (!bus.op_valid || m_accepted) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.op_valid = 1'b1;
                    bus.op_code  = 4'($urandom_range(0, 15));
                    case ($urandom_range(0, 5))
                        0:       bus.op_dr = 16'h0000;
                        1:       bus.op_dr = 16'hFFFF;
                        2:       bus.op_dr = 16'h7FFF;
                        3:       bus.op_dr = 16'h8000;
                        default: bus.op_dr = 16'($urandom);
                    endcase
                end else begin
                    bus.op_valid = 1'b0;
                end
            end
        end
        @(posedge clk); #2;
        rst = 1'b0; ovf_clr = 1'b0; bus.op_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
